// File: rtl/blk_com_fifo_pkt_rd.sv
// rtl/blk_com_fifo_pkt_rd.sv - store-and-forward packet read stage behind the common sync FIFO
// Prefetches FIFO words into a 3-entry buffer and releases a packet's SOP only once it is committed.
module blk_com_fifo_pkt_rd #(
  parameter int DATA_W    = 32,
  parameter int PKT_CNT_W = 10
) (
  input  logic                 I_fifo_clk,
  input  logic                 I_fifo_rst,
  input  logic                 I_pkt_wr_done,
  input  logic [DATA_W:0]      I_fifo_dout,
  input  logic                 I_fifo_empty,
  output logic                 O_fifo_rd,
  output logic                 O_pkt_valid,
  input  logic                 I_pkt_ready,
  output logic [DATA_W-1:0]    O_pkt_data,
  output logic                 O_pkt_sop,
  output logic                 O_pkt_eop,
  output logic [PKT_CNT_W-1:0] O_pkt_cnt,
  output logic                 O_cnt_err
);

  localparam int ENT_W = DATA_W + 2;
  localparam logic [PKT_CNT_W-1:0] CNT_ONE = {{(PKT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PKT_CNT_W-1:0] CNT_MAX = {PKT_CNT_W{1'b1}};

  // Entry layout: {sop, eop, data}; entry 0 is the head, entries at or above occ are kept zero.
  logic [ENT_W-1:0]     buf_q [3];
  logic [ENT_W-1:0]     buf_d [3];
  logic [1:0]           occ_q, occ_d;
  logic                 infl_q;
  logic                 sop_next_q, sop_next_d;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [ENT_W-1:0] head;
  logic             head_sop;
  logic             pop;
  logic             push;
  logic             dec;
  logic [1:0]       wr_idx;
  logic [2:0]       pending;

  assign head     = buf_q[0];
  assign head_sop = head[ENT_W-1];
  assign pending  = {1'b0, occ_q} + {2'b00, infl_q};

  // Read issue looks only at registered state, so it never waits on downstream ready.
  always_comb begin
    O_fifo_rd = !I_fifo_rst && !I_fifo_empty && (pending <= 3'd2);
  end

  always_comb begin
    O_pkt_valid = (occ_q != 2'd0) && (!head_sop || (cnt_q != '0));
    O_pkt_data  = '0;
    O_pkt_sop   = 1'b0;
    O_pkt_eop   = 1'b0;
    if (occ_q != 2'd0) begin
      O_pkt_data = head[DATA_W-1:0];
      O_pkt_sop  = head_sop;
      O_pkt_eop  = head[ENT_W-2];
    end
    O_pkt_cnt = cnt_q;
    O_cnt_err = err_q;
  end

  assign pop    = O_pkt_valid && I_pkt_ready;
  assign push   = infl_q;
  assign dec    = pop && head_sop;
  assign wr_idx = occ_q - {1'b0, pop};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      buf_d[i] = buf_q[i];
    end
    if (pop) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
      buf_d[2] = '0;
    end
    // The read-issue limit keeps wr_idx within 0..2 whenever a word returns.
    if (push) begin
      buf_d[wr_idx] = {sop_next_q, I_fifo_dout[DATA_W], I_fifo_dout[DATA_W-1:0]};
    end
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    sop_next_d = push ? I_fifo_dout[DATA_W] : sop_next_q;
  end

  // Commit counter: a coincident commit and SOP accept cancel; overflow saturates and latches the error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (I_pkt_wr_done && !dec) begin
      if (cnt_q == CNT_MAX) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (dec && !I_pkt_wr_done) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge I_fifo_clk) begin
    if (I_fifo_rst) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
      occ_q      <= 2'd0;
      infl_q     <= 1'b0;
      sop_next_q <= 1'b1;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= buf_d[i];
      end
      occ_q      <= occ_d;
      infl_q     <= O_fifo_rd;
      sop_next_q <= sop_next_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/blk_com_fifo_pkt_rd.md
Name: blk_com_fifo_pkt_rd

Overview:
- Store-and-forward read stage placed directly downstream of the 512x33 common sync FIFO.
- Pops 33-bit words, where bit32 = EOP and [31:0] = data, from the FIFO. The FIFO uses standard mode with 1-cycle read latency.
- Re-frames the words into a SOP/EOP valid/ready stream.
- Presents a packet only after the upstream writer has committed it in full, so no partial packet ever leaves the block.

Parameters:
- DATA_W, 32: payload width; FIFO word width is DATA_W+1.
- PKT_CNT_W, 10: width of the committed-packet counter; saturates at 2^PKT_CNT_W-1.

Ports:
- I_fifo_clk  in  1  clock, shared with the FIFO
- I_fifo_rst  in  1  synchronous active-high reset; the same reset drives the FIFO
- I_pkt_wr_done  in  1  one-cycle pulse from the writer when the EOP word of a packet has been written to the FIFO
- I_fifo_dout  in  33  FIFO read data, valid the cycle after O_fifo_rd
- I_fifo_empty  in  1  FIFO empty flag
- O_fifo_rd  out  1  FIFO read strobe
- O_pkt_valid  out  1  output beat valid
- I_pkt_ready  in  1  downstream ready
- O_pkt_data  out  DATA_W  output payload
- O_pkt_sop  out  1  first beat of packet
- O_pkt_eop  out  1  last beat of packet
- O_pkt_cnt  out  PKT_CNT_W  committed packets not yet started at the output
- O_cnt_err  out  1  sticky error: commit counter overflow

Behaviour:
- Reset (synchronous, active-high): every output is 0.
  - Buffer occupancy, in-flight flag and commit counter are cleared.
  - The sop_next flag is set to 1.
  - O_cnt_err is cleared.
  - Reset has priority over every other event. Any read in flight at reset is discarded.
- Output buffer: 3-entry FIFO of {sop, eop, data}.
  - occ = occupancy, 0..3.
  - infl = 1 when a read was issued last cycle.
- Read issue:
  - O_fifo_rd = !I_fifo_empty && (occ + infl <= 2).
  - Depends on registered state and I_fifo_empty only; there is no combinational path from I_pkt_ready.
- Read return:
  - When infl = 1, I_fifo_dout is written into the buffer tail with sop = sop_next and eop = I_fifo_dout[32].
  - sop_next <= I_fifo_dout[32].
- Reads are not gated by packet commit. Words of an uncommitted packet may prefetch into the buffer, at most 3 words plus 0 in flight.
- Commit counter cnt:
  - +1 on I_pkt_wr_done.
  - -1 on output accept (O_pkt_valid && I_pkt_ready) of a beat with sop = 1.
  - Both in the same cycle: cnt unchanged.
  - Increment when cnt = max: cnt holds at max and O_cnt_err <= 1 (sticky until reset).
  - O_pkt_cnt = cnt.
- O_pkt_valid = (occ != 0) && (!head.sop || cnt != 0).
  - Mid-packet beats flow freely.
  - A SOP beat waits for a commit.
- O_pkt_data, O_pkt_sop and O_pkt_eop show the buffer head whenever occ != 0, and are 0 when occ = 0.
  - Head fields are held stable while O_pkt_valid && !I_pkt_ready.
- Pop and push in the same cycle: occ unchanged, order preserved.
  - The read-issue rule guarantees a push never meets occ = 3.
- Single-word packet: FIFO bit32 = 1 on a word with sop_next = 1 gives sop = eop = 1 on the same beat.
- Latency:
  - Empty block, FIFO non-empty at cycle t: O_fifo_rd at t, word in buffer at t+2.
  - O_pkt_valid at t+2 if the packet was already committed.
  - Commit pulse at t with the head SOP already buffered: O_pkt_valid at t+1.
- Throughput: 1 beat/cycle sustained with I_pkt_ready = 1 and data available (occ 1, infl 1 steady state).
- Invariants:
  - O_fifo_rd is never asserted with I_fifo_empty = 1.
  - occ never exceeds 3.
  - No word is dropped or duplicated.

Test Plan:
- Reset: assert I_fifo_rst for 2 cycles mid-stream -> all outputs 0 the cycle after, cnt = 0, first post-reset beat carries sop = 1.
- Gating: write a 4-word packet 0xA0..0xA3 (EOP on 0xA3) with no wr_done -> exactly 3 reads issued, O_pkt_valid stays 0. Pulse wr_done -> 0xA0 (sop) .. 0xA3 (eop) on 4 consecutive accepts, O_pkt_cnt goes 1 -> 0.
- Throughput: 10 committed 8-word packets, I_pkt_ready = 1 -> 80 beats on 80 consecutive cycles after first-beat latency of 2, with 10 sop and 10 eop.
- Backpressure: same traffic with I_pkt_ready random 50% -> scoreboard matches in order, data held stable while stalled, occ <= 3, no read on empty.
- Single-word packets with a wr_done pulse coinciding with a SOP accept -> sop = eop = 1 per beat, O_pkt_cnt unchanged in coincident cycles.
- Overflow: 1024 wr_done pulses with I_pkt_ready = 0 -> O_pkt_cnt = 1023, O_cnt_err = 1 and stays 1 until reset.
